// File: rtl/ram_access_arbiter_if.sv
// Client request/grant/read-return signals and the RAM-side bus for ram_access_arbiter.
// The slave modport is the arbiter's view; the master modport is the clients' view.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_gnt;
  logic              c0_rvalid;
  logic [DATA_W-1:0] c0_rdata;

  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_gnt;
  logic              c1_rvalid;
  logic [DATA_W-1:0] c1_rdata;

  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_read_data;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_gnt, c0_rvalid, c0_rdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    output ram_write_en, ram_write_addr, ram_write_data,
    output ram_read_en, ram_read_addr,
    input  ram_read_data
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_gnt, c0_rvalid, c0_rdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    input  ram_write_en, ram_write_addr, ram_write_data,
    input  ram_read_en, ram_read_addr,
    output ram_read_data
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Shares one simple dual-port RAM between two clients: clears the RAM after reset,
// then grants one write and one read per cycle with round-robin on same-op contention.
module ram_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = (1 << ADDR_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_access_arbiter_if.slave    bus,
  output logic                   init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              rr_q, rr_d;
  logic              rd_pending_q, rd_pending_d;
  logic              rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;

  logic w0, w1, r0, r1;
  logic wg0, wg1, rg0, rg1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      rr_q         <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      hold0_q      <= '0;
      hold1_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_done_q  <= init_done_d;
      rr_q         <= rr_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    init_done_d    = init_done_q;
    rr_d           = rr_q;
    rd_pending_d   = 1'b0;
    rd_owner_d     = rd_owner_q;
    hold0_d        = hold0_q;
    hold1_d        = hold1_q;

    w0  = bus.c0_req &  bus.c0_we;
    w1  = bus.c1_req &  bus.c1_we;
    r0  = bus.c0_req & ~bus.c0_we;
    r1  = bus.c1_req & ~bus.c1_we;
    wg0 = 1'b0;
    wg1 = 1'b0;
    rg0 = 1'b0;
    rg1 = 1'b0;

    bus.c0_gnt         = 1'b0;
    bus.c1_gnt         = 1'b0;
    bus.ram_write_en   = 1'b0;
    bus.ram_write_addr = '0;
    bus.ram_write_data = '0;
    bus.ram_read_en    = 1'b0;
    bus.ram_read_addr  = '0;

    // Outputs are held quiet while rst is high so an in-flight read never strobes.
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          bus.ram_write_en   = 1'b1;
          bus.ram_write_addr = cnt_q;
          if (cnt_q == LAST_ADDR) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // rr_q names the favoured client; only one port can be contended at a time.
          wg0 = w0 & (~w1 | ~rr_q);
          wg1 = w1 & (~w0 |  rr_q);
          rg0 = r0 & (~r1 | ~rr_q);
          rg1 = r1 & (~r0 |  rr_q);
          if ((w0 & w1) | (r0 & r1)) rr_d = ~rr_q;

          bus.c0_gnt       = wg0 | rg0;
          bus.c1_gnt       = wg1 | rg1;
          bus.ram_write_en = wg0 | wg1;
          bus.ram_read_en  = rg0 | rg1;
          if (wg1) begin
            bus.ram_write_addr = bus.c1_addr;
            bus.ram_write_data = bus.c1_wdata;
          end else if (wg0) begin
            bus.ram_write_addr = bus.c0_addr;
            bus.ram_write_data = bus.c0_wdata;
          end
          if (rg1)      bus.ram_read_addr = bus.c1_addr;
          else if (rg0) bus.ram_read_addr = bus.c0_addr;
          if (rg0 | rg1) begin
            rd_pending_d = 1'b1;
            rd_owner_d   = rg1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    bus.c0_rvalid = rd_pending_q & ~rd_owner_q & ~rst;
    bus.c1_rvalid = rd_pending_q &  rd_owner_q & ~rst;
    bus.c0_rdata  = bus.c0_rvalid ? bus.ram_read_data : hold0_q;
    bus.c1_rdata  = bus.c1_rvalid ? bus.ram_read_data : hold1_q;
    hold0_d       = bus.c0_rdata;
    hold1_d       = bus.c1_rdata;
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a registered-read RAM model attached.
module tb_ram_access_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst;
  logic init_done;
  int   n_vec = 0;
  int   n_err = 0;
  logic [DATA_W-1:0] mem [DEPTH];

  ram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_write_addr] <= bus.ram_write_data;
    if (rst)                  bus.ram_read_data <= '0;
    else if (bus.ram_read_en) bus.ram_read_data <= mem[bus.ram_read_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.c0_req = 1'b0; bus.c0_we = 1'b0; bus.c0_addr = '0; bus.c0_wdata = '0;
    bus.c1_req = 1'b0; bus.c1_we = 1'b0; bus.c1_addr = '0; bus.c1_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'hA;
    idle();
    rst = 1'b1;
    repeat (3) next_cycle();

    // Reset state and idle sweep, c0 read of addr 0 pending throughout
    @(negedge clk);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_c0_rvalid", 32'(bus.c0_rvalid), 32'd0);
    check("rst_c0_rdata", 32'(bus.c0_rdata), 32'd0);
    check("rst_ren", 32'(bus.ram_read_en), 32'd0);
    next_cycle();
    rst = 1'b0;
    bus.c0_req = 1'b1; bus.c0_we = 1'b0; bus.c0_addr = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("init_wen", 32'(bus.ram_write_en), 32'd1);
      check("init_waddr", 32'(bus.ram_write_addr), 32'(i));
      check("init_wdata", 32'(bus.ram_write_data), 32'd0);
      check("init_ren", 32'(bus.ram_read_en), 32'd0);
      check("init_c0_gnt", 32'(bus.c0_gnt), 32'd0);
      check("init_done_low", 32'(init_done), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("init_done_high", 32'(init_done), 32'd1);
    check("run_wen_idle", 32'(bus.ram_write_en), 32'd0);
    check("t1_c0_gnt", 32'(bus.c0_gnt), 32'd1);
    check("t1_raddr", 32'(bus.ram_read_addr), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t1_c0_rvalid", 32'(bus.c0_rvalid), 32'd1);
    check("t1_c0_rdata", 32'(bus.c0_rdata), 32'd0);
    next_cycle();

    // Dual write contention, c0 favoured first
    bus.c0_req = 1'b1; bus.c0_we = 1'b1; bus.c0_addr = 8'd5; bus.c0_wdata = 4'd3;
    bus.c1_req = 1'b1; bus.c1_we = 1'b1; bus.c1_addr = 8'd6; bus.c1_wdata = 4'd9;
    @(negedge clk);
    check("t2a_c0_gnt", 32'(bus.c0_gnt), 32'd1);
    check("t2a_c1_gnt", 32'(bus.c1_gnt), 32'd0);
    check("t2a_waddr", 32'(bus.ram_write_addr), 32'd5);
    check("t2a_wdata", 32'(bus.ram_write_data), 32'd3);
    next_cycle();
    bus.c0_req = 1'b0;
    @(negedge clk);
    check("t2b_c0_gnt", 32'(bus.c0_gnt), 32'd0);
    check("t2b_c1_gnt", 32'(bus.c1_gnt), 32'd1);
    check("t2b_waddr", 32'(bus.ram_write_addr), 32'd6);
    check("t2b_wdata", 32'(bus.ram_write_data), 32'd9);
    next_cycle();
    idle();

    // c0 write + c1 read of the same address: both granted, read sees old data
    bus.c0_req = 1'b1; bus.c0_we = 1'b1; bus.c0_addr = 8'd10; bus.c0_wdata = 4'd7;
    bus.c1_req = 1'b1; bus.c1_we = 1'b0; bus.c1_addr = 8'd10;
    @(negedge clk);
    check("t3_c0_gnt", 32'(bus.c0_gnt), 32'd1);
    check("t3_c1_gnt", 32'(bus.c1_gnt), 32'd1);
    check("t3_wen", 32'(bus.ram_write_en), 32'd1);
    check("t3_ren", 32'(bus.ram_read_en), 32'd1);
    check("t3_raddr", 32'(bus.ram_read_addr), 32'd10);
    next_cycle();
    idle();
    @(negedge clk);
    check("t3_c1_rvalid", 32'(bus.c1_rvalid), 32'd1);
    check("t3_c0_rvalid", 32'(bus.c0_rvalid), 32'd0);
    check("t3_c1_rdata_old", 32'(bus.c1_rdata), 32'd0);
    next_cycle();
    bus.c1_req = 1'b1; bus.c1_we = 1'b0; bus.c1_addr = 8'd10;
    @(negedge clk);
    check("t3r_c1_gnt", 32'(bus.c1_gnt), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("t3r_c1_rvalid", 32'(bus.c1_rvalid), 32'd1);
    check("t3r_c1_rdata", 32'(bus.c1_rdata), 32'd7);
    next_cycle();
    @(negedge clk);
    check("t3r_c1_rvalid_off", 32'(bus.c1_rvalid), 32'd0);
    check("t3r_c1_rdata_hold", 32'(bus.c1_rdata), 32'd7);
    next_cycle();

    // Back-to-back reads from different clients
    bus.c0_req = 1'b1; bus.c0_we = 1'b0; bus.c0_addr = 8'd5;
    @(negedge clk);
    check("t4_c0_gnt", 32'(bus.c0_gnt), 32'd1);
    next_cycle();
    bus.c0_req = 1'b0;
    bus.c1_req = 1'b1; bus.c1_we = 1'b0; bus.c1_addr = 8'd6;
    @(negedge clk);
    check("t4_c1_gnt", 32'(bus.c1_gnt), 32'd1);
    check("t4_c0_rvalid", 32'(bus.c0_rvalid), 32'd1);
    check("t4_c0_rdata", 32'(bus.c0_rdata), 32'd3);
    check("t4_c1_rvalid_early", 32'(bus.c1_rvalid), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t4_c1_rvalid", 32'(bus.c1_rvalid), 32'd1);
    check("t4_c1_rdata", 32'(bus.c1_rdata), 32'd9);
    check("t4_c0_rvalid_off", 32'(bus.c0_rvalid), 32'd0);
    check("t4_c0_rdata_hold", 32'(bus.c0_rdata), 32'd3);
    next_cycle();

    // Read contention: c1 favoured after the earlier write contention
    bus.c0_req = 1'b1; bus.c0_we = 1'b0; bus.c0_addr = 8'd5;
    bus.c1_req = 1'b1; bus.c1_we = 1'b0; bus.c1_addr = 8'd6;
    @(negedge clk);
    check("rc_c0_gnt", 32'(bus.c0_gnt), 32'd0);
    check("rc_c1_gnt", 32'(bus.c1_gnt), 32'd1);
    check("rc_raddr", 32'(bus.ram_read_addr), 32'd6);
    next_cycle();
    bus.c1_req = 1'b0;
    @(negedge clk);
    check("rc2_c0_gnt", 32'(bus.c0_gnt), 32'd1);
    check("rc2_raddr", 32'(bus.ram_read_addr), 32'd5);
    check("rc2_c1_rdata", 32'(bus.c1_rdata), 32'd9);
    next_cycle();
    idle();
    @(negedge clk);
    check("rc2_c0_rdata", 32'(bus.c0_rdata), 32'd3);
    next_cycle();

    // Sustained dual-write contention alternates c0,c1,...
    bus.c0_req = 1'b1; bus.c0_we = 1'b1; bus.c0_addr = 8'd20; bus.c0_wdata = 4'd1;
    bus.c1_req = 1'b1; bus.c1_we = 1'b1; bus.c1_addr = 8'd21; bus.c1_wdata = 4'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_c0_gnt", 32'(bus.c0_gnt), 32'(i % 2 == 0));
      check("t5_c1_gnt", 32'(bus.c1_gnt), 32'(i % 2 == 1));
      check("t5_waddr", 32'(bus.ram_write_addr), (i % 2 == 0) ? 32'd20 : 32'd21);
      next_cycle();
    end
    idle();

    // Reset right after a granted read drops the return and restarts the sweep
    bus.c0_req = 1'b1; bus.c0_we = 1'b0; bus.c0_addr = 8'd5;
    @(negedge clk);
    check("t6_c0_gnt", 32'(bus.c0_gnt), 32'd1);
    next_cycle();
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("t6_c0_rvalid_rst", 32'(bus.c0_rvalid), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t6_init_done", 32'(init_done), 32'd0);
      check("t6_c0_rvalid", 32'(bus.c0_rvalid), 32'd0);
      check("t6_wen", 32'(bus.ram_write_en), 32'd1);
      check("t6_waddr", 32'(bus.ram_write_addr), 32'(i));
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
